// File: rtl/fb_pixel_packer.sv
// fb_pixel_packer: packs RGB565 pixels into masked 64-bit PSRAM words
// and queues them for the arbiter write port through a 2-entry FIFO.
module fb_pixel_packer #(
    parameter int FB_WIDTH     = 1280,
    parameter int FB_HEIGHT    = 720,
    parameter int FLUSH_CYCLES = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_pixel_data,
    input  logic [31:0] i_col_addr,
    input  logic [31:0] i_row_addr,
    input  logic        i_waddr_set_req,
    input  logic        i_write_req,
    output logic [20:0] o_psram_addr,
    output logic [63:0] o_psram_data,
    output logic [7:0]  o_psram_data_mask,
    output logic        o_psram_write_req,
    input  logic        i_psram_write_gnt,
    output logic        o_busy,
    output logic        o_overflow
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [15:0] W16 = 16'(FB_WIDTH);
    localparam logic [15:0] H16 = 16'(FB_HEIGHT);
    localparam logic [20:0] W21 = 21'(FB_WIDTH);

    logic [15:0]   x, y;
    logic [20:0]   row_base;
    logic [20:0]   acc_addr;
    logic [63:0]   acc_data;
    logic [7:0]    acc_mask;
    logic          acc_pend;
    logic [CW-1:0] idle_cnt;

    logic [20:0] q_addr [2];
    logic [63:0] q_data [2];
    logic [7:0]  q_mask [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  q_cnt;

    logic [15:0] xs, xe, ys, ye;
    logic [15:0] cx, cy, nx, ny;
    logic [20:0] ys_base, crb;
    logic [22:0] lin;
    logic [20:0] pix_addr;
    logic [1:0]  lane;
    logic        in_frame, wr_in, acc_empty, idle_hit;
    logic        old_close, new_close, fresh;
    logic [7:0]  new_mask;
    logic [63:0] new_data, lane_sel;
    logic        push, pop, full, do_push, drop;
    logic [20:0] push_addr;
    logic [63:0] push_data;
    logic [7:0]  push_mask;

    assign xs = i_col_addr[31:16];
    assign xe = i_col_addr[15:0];
    assign ys = i_row_addr[31:16];
    assign ye = i_row_addr[15:0];

    // A set request in the same cycle as a pixel retargets that pixel
    assign ys_base = 21'(ys * FB_WIDTH);
    assign cx  = i_waddr_set_req ? xs : x;
    assign cy  = i_waddr_set_req ? ys : y;
    assign crb = i_waddr_set_req ? ys_base : row_base;
    assign nx  = cx + 16'd1;
    assign ny  = cy + 16'd1;

    assign lin      = {2'b00, crb} + {7'd0, cx};
    assign pix_addr = 21'(lin >> 2);
    assign lane     = cx[1:0];
    assign in_frame = (cx < W16) && (cy < H16);
    assign wr_in    = i_write_req && in_frame;

    assign acc_empty = (acc_mask == 8'hFF);
    assign idle_hit  = !i_write_req && !acc_empty
                    && (idle_cnt == CW'(FLUSH_CYCLES - 1));

    assign old_close = !acc_empty && (acc_pend || i_waddr_set_req || idle_hit
                    || (wr_in && (pix_addr != acc_addr)));
    assign fresh     = old_close || acc_empty;
    assign new_close = wr_in && (lane == 2'd3);

    assign lane_sel = 64'hFFFF << {lane, 4'b0000};
    assign new_mask = (fresh ? 8'hFF : acc_mask) & ~(8'b11 << {lane, 1'b0});
    assign new_data = ((fresh ? 64'd0 : acc_data) & ~lane_sel)
                    | (64'(i_pixel_data) << {lane, 4'b0000});

    // The old word takes the single push slot; a closing new word waits
    assign push      = old_close || new_close;
    assign push_addr = old_close ? acc_addr : pix_addr;
    assign push_data = old_close ? acc_data : new_data;
    assign push_mask = old_close ? acc_mask : new_mask;

    assign pop     = i_psram_write_gnt && (q_cnt != 2'd0);
    assign full    = (q_cnt == 2'd2);
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x          <= '0;
            y          <= '0;
            row_base   <= '0;
            acc_addr   <= '0;
            acc_data   <= '0;
            acc_mask   <= 8'hFF;
            acc_pend   <= 1'b0;
            idle_cnt   <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            q_cnt      <= 2'd0;
            o_overflow <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
                q_mask[i] <= 8'hFF;
            end
        end else begin
            if (i_write_req) begin
                if (nx == xe) begin
                    x <= xs;
                    if (ny == ye) begin
                        y        <= ys;
                        row_base <= ys_base;
                    end else begin
                        y        <= ny;
                        row_base <= crb + W21;
                    end
                end else begin
                    x        <= nx;
                    y        <= cy;
                    row_base <= crb;
                end
            end else if (i_waddr_set_req) begin
                x        <= xs;
                y        <= ys;
                row_base <= ys_base;
            end

            if (old_close) begin
                if (wr_in) begin
                    acc_addr <= pix_addr;
                    acc_data <= new_data;
                    acc_mask <= new_mask;
                    acc_pend <= new_close;
                end else begin
                    acc_mask <= 8'hFF;
                    acc_pend <= 1'b0;
                end
            end else if (new_close) begin
                acc_mask <= 8'hFF;
                acc_pend <= 1'b0;
            end else if (wr_in) begin
                acc_addr <= pix_addr;
                acc_data <= new_data;
                acc_mask <= new_mask;
            end

            if (i_write_req || acc_empty || idle_hit)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;

            if (do_push) begin
                q_addr[wr_ptr] <= push_addr;
                q_data[wr_ptr] <= push_data;
                q_mask[wr_ptr] <= push_mask;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            unique case ({do_push, pop})
                2'b10:   q_cnt <= q_cnt + 2'd1;
                2'b01:   q_cnt <= q_cnt - 2'd1;
                default: q_cnt <= q_cnt;
            endcase

            if (drop)
                o_overflow <= 1'b1;
            else if (i_waddr_set_req)
                o_overflow <= 1'b0;
        end
    end

    assign o_psram_write_req = (q_cnt != 2'd0);
    assign o_psram_addr      = o_psram_write_req ? q_addr[rd_ptr] : 21'd0;
    assign o_psram_data      = o_psram_write_req ? q_data[rd_ptr] : 64'd0;
    assign o_psram_data_mask = o_psram_write_req ? q_mask[rd_ptr] : 8'hFF;
    assign o_busy            = !acc_empty || o_psram_write_req;

endmodule
